// File: rtl/nn_sched_pkg.sv
// nn_sched_pkg
//   Shared types and helpers for the CNN layer sequencer.
//   - seq_state_e   : sequencer FSM states
//   - idx3_t        : {ch,row,col} index triple at the default 16-bit width
//   - layer_table_t : zero-extended container for the packed per-layer tables
//   - layer_ch/layer_dim : pull layer k's 16-bit entry out of a packed table
package nn_sched_pkg;

  localparam int MAX_LAYERS = 64;
  localparam int FIELD_W    = 16;
  localparam int SEQ_IDX_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_XFER,
    S_DRAIN,
    S_DONE
  } seq_state_e;

  typedef struct packed {
    logic [SEQ_IDX_W-1:0] ch;
    logic [SEQ_IDX_W-1:0] row;
    logic [SEQ_IDX_W-1:0] col;
  } idx3_t;

  typedef logic [MAX_LAYERS*FIELD_W-1:0] layer_table_t;

  // Layer k's output channel count lives at bits [16k +: 16].
  function automatic logic [FIELD_W-1:0] layer_ch(input layer_table_t tbl, input int k);
    return tbl[FIELD_W*k +: FIELD_W];
  endfunction

  // Layer k's output height (== width) lives at bits [16k +: 16].
  function automatic logic [FIELD_W-1:0] layer_dim(input layer_table_t tbl, input int k);
    return tbl[FIELD_W*k +: FIELD_W];
  endfunction

endpackage

// File: rtl/index_walker.sv
// index_walker
//   Three-level wrapping counter producing a {ch,row,col} walk, col fastest.
//   col and row wrap at dim_bound-1, ch wraps at ch_bound-1.
// Ports
//   clk, reset      : clock, async active-low reset
//   clear           : synchronous return to {0,0,0}, wins over step
//   step            : advance one position
//   ch_bound        : number of channels (>=1)
//   dim_bound       : rows == cols (>=1)
//   ch, row, col    : current position
//   last            : current position is the final one of the walk
module index_walker #(
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  input  logic [IDX_W-1:0] ch_bound,
  input  logic [IDX_W-1:0] dim_bound,
  output logic [IDX_W-1:0] ch,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);

  logic [IDX_W-1:0] dim_max;
  logic [IDX_W-1:0] ch_max;
  logic             col_wrap;
  logic             row_wrap;
  logic             ch_wrap;

  assign dim_max  = dim_bound - IDX_W'(1);
  assign ch_max   = ch_bound - IDX_W'(1);
  assign col_wrap = (col == dim_max);
  assign row_wrap = (row == dim_max);
  assign ch_wrap  = (ch == ch_max);
  assign last     = col_wrap && row_wrap && ch_wrap;

  // Carry ripples col -> row -> ch; the whole walk returns to zero after last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch  <= '0;
      row <= '0;
      col <= '0;
    end else if (clear) begin
      ch  <= '0;
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (col_wrap) begin
        col <= '0;
        if (row_wrap) begin
          row <= '0;
          ch  <= ch_wrap ? '0 : ch + IDX_W'(1);
        end else begin
          row <= row + IDX_W'(1);
        end
      end else begin
        col <= col + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Frame scheduler for an N-layer CNN pipeline. Starts each layer, waits for
//   its done, then copies that layer's output memory into the next layer's
//   input memory by walking {ch,row,col}. Output memory has 1-cycle read
//   latency, so writes trail reads by one cycle.
// Optional feature macro: LAYER_SEQ_PERF_EN adds perf_cycles (frame length).
// Ports
//   clk, reset     : clock, async active-low reset
//   start, abort   : frame begin / cancel pulses
//   busy           : frame in progress
//   frame_done     : one-cycle pulse at end of frame
//   cur_layer      : layer computing or being drained
//   layer_start    : one-cycle start pulse per layer
//   layer_done     : per-layer done (level or pulse)
//   xfer_rd_index  : {ch,row,col} read address into outmem of cur_layer
//   xfer_wr_index  : {ch,row,col} write address into inmem of cur_layer+1
//   xfer_write     : one-hot inmem write enable
//   perf_cycles    : cycles of last completed frame (LAYER_SEQ_PERF_EN only)
module layer_sequencer
  import nn_sched_pkg::*;
#(
  parameter int                       NUM_LAYERS = 3,
  parameter int                       IDX_W      = 16,
  parameter logic [NUM_LAYERS*16-1:0] LAYER_CH   = {16'd32, 16'd16, 16'd16},
  parameter logic [NUM_LAYERS*16-1:0] LAYER_DIM  = {16'd11, 16'd13, 16'd26}
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(NUM_LAYERS)-1:0] cur_layer,
  output logic [NUM_LAYERS-1:0]         layer_start,
  input  logic [NUM_LAYERS-1:0]         layer_done,
  output logic [3*IDX_W-1:0]            xfer_rd_index,
  output logic [3*IDX_W-1:0]            xfer_wr_index,
  output logic [NUM_LAYERS-1:0]         xfer_write
`ifdef LAYER_SEQ_PERF_EN
  ,
  output logic [31:0]                   perf_cycles
`endif
);

  localparam int              CL_W       = $clog2(NUM_LAYERS);
  localparam logic [CL_W-1:0] LAST_LAYER = CL_W'(NUM_LAYERS - 1);

  // Reject configurations whose counts would not fit the index counters.
  if (NUM_LAYERS < 2 || NUM_LAYERS > MAX_LAYERS) begin : g_bad_num_layers
    $error("layer_sequencer: NUM_LAYERS must be in 2..%0d", MAX_LAYERS);
  end
  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_chk_layer
    if (LAYER_CH[16*k +: 16] == 16'd0 || LAYER_DIM[16*k +: 16] == 16'd0) begin : g_zero
      $error("layer_sequencer: layer %0d has zero CH or DIM", k);
    end
    if (IDX_W < 16) begin : g_narrow
      if ((LAYER_CH[16*k +: 16] >> IDX_W) != 16'd0 ||
          (LAYER_DIM[16*k +: 16] >> IDX_W) != 16'd0) begin : g_ovf
        $error("layer_sequencer: layer %0d CH/DIM exceeds IDX_W", k);
      end
    end
  end

  seq_state_e       state;
  seq_state_e       next_state;
  logic [IDX_W-1:0] ch_bound;
  logic [IDX_W-1:0] dim_bound;
  logic [IDX_W-1:0] walk_ch;
  logic [IDX_W-1:0] walk_row;
  logic [IDX_W-1:0] walk_col;
  logic             walk_last;
  logic             walk_clear;
  logic             wr_valid;
  logic             abort_frame;

  assign abort_frame = abort && (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Abort overrides every non-idle transition; in IDLE it also blocks start.
  // Only the current layer's done is looked at, and only while waiting.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start && !abort) next_state = S_RUN;
      S_RUN:   next_state = S_WAIT;
      S_WAIT:  if (layer_done[cur_layer]) next_state = (cur_layer == LAST_LAYER) ? S_DONE : S_XFER;
      S_XFER:  if (walk_last) next_state = S_DRAIN;
      S_DRAIN: next_state = S_RUN;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (abort_frame) next_state = S_IDLE;
  end

  always_comb begin
    busy        = (state != S_IDLE);
    frame_done  = (state == S_DONE);
    layer_start = '0;
    xfer_write  = '0;
    if (state == S_RUN) layer_start = NUM_LAYERS'(1) << cur_layer;
    if (wr_valid)       xfer_write  = NUM_LAYERS'(2) << cur_layer;
  end

  // cur_layer only advances as DRAIN hands over to the next layer's RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_layer <= '0;
    end else if (abort_frame || state == S_IDLE) begin
      cur_layer <= '0;
    end else if (state == S_DRAIN) begin
      cur_layer <= cur_layer + CL_W'(1);
    end
  end

  always_comb begin
    ch_bound  = '0;
    dim_bound = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (cur_layer == CL_W'(k)) begin
        ch_bound  = IDX_W'(layer_ch(layer_table_t'(LAYER_CH), k));
        dim_bound = IDX_W'(layer_dim(layer_table_t'(LAYER_DIM), k));
      end
    end
  end

  // Keyed on next_state so the walk sits at {0,0,0} on the first XFER cycle
  // and returns to zero immediately on DRAIN or abort.
  assign walk_clear = (next_state != S_XFER);

  index_walker #(
    .IDX_W(IDX_W)
  ) u_walker (
    .clk       (clk),
    .reset     (reset),
    .clear     (walk_clear),
    .step      (state == S_XFER),
    .ch_bound  (ch_bound),
    .dim_bound (dim_bound),
    .ch        (walk_ch),
    .row       (walk_row),
    .col       (walk_col),
    .last      (walk_last)
  );

  assign xfer_rd_index = {walk_ch, walk_row, walk_col};

  // One-stage delay matching the outmem read latency. The read issued on the
  // last XFER cycle lands in DRAIN; an abort drops whatever is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_valid      <= 1'b0;
      xfer_wr_index <= '0;
    end else if (abort_frame) begin
      wr_valid      <= 1'b0;
      xfer_wr_index <= '0;
    end else begin
      wr_valid <= (state == S_XFER);
      if (state == S_XFER) xfer_wr_index <= xfer_rd_index;
    end
  end

`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] frame_cycles;
  logic [31:0] frame_cycles_inc;

  assign frame_cycles_inc = (frame_cycles == 32'hFFFF_FFFF) ? frame_cycles
                                                            : frame_cycles + 32'd1;

  // frame_cycles already holds the accept cycle when RUN begins, so the
  // value latched in DONE covers accept through frame_done inclusive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cycles <= '0;
      perf_cycles  <= '0;
    end else begin
      if (state == S_IDLE) begin
        if (start && !abort) frame_cycles <= 32'd1;
      end else begin
        frame_cycles <= frame_cycles_inc;
      end
      if (state == S_DONE) perf_cycles <= frame_cycles_inc;
    end
  end
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer
//   Directed bench for layer_sequencer. Instance A uses the default 3-layer
//   configuration with an auto-responder that raises layer_done 5 cycles after
//   each layer_start; instance B is a tiny 2-layer build whose write sequence
//   is checked against a hand-written table.
//   Build with LAYER_SEQ_PERF_EN defined to also check perf_cycles.
module tb_layer_sequencer;
  import nn_sched_pkg::*;

  localparam int FRAME_LEN = 13542;
  localparam int L1_WRITES = 10816;
  localparam int L2_WRITES = 2704;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        start_a, abort_a, busy_a, frame_done_a;
  logic [1:0]  cur_layer_a;
  logic [2:0]  layer_start_a, layer_done_a, xfer_write_a;
  logic [47:0] rd_a, wr_a;
  logic [2:0]  auto_done = '0;
  logic [2:0]  extra_done;
  assign layer_done_a = auto_done | extra_done;

  logic        start_b, abort_b, busy_b, frame_done_b;
  logic [0:0]  cur_layer_b;
  logic [1:0]  layer_start_b, layer_done_b, xfer_write_b;
  logic [47:0] rd_b, wr_b;

`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] perf_a, perf_b;
`endif

  layer_sequencer u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .busy(busy_a), .frame_done(frame_done_a), .cur_layer(cur_layer_a),
    .layer_start(layer_start_a), .layer_done(layer_done_a),
    .xfer_rd_index(rd_a), .xfer_wr_index(wr_a), .xfer_write(xfer_write_a)
`ifdef LAYER_SEQ_PERF_EN
    , .perf_cycles(perf_a)
`endif
  );

  layer_sequencer #(
    .NUM_LAYERS(2), .IDX_W(16),
    .LAYER_CH({16'd1, 16'd2}), .LAYER_DIM({16'd1, 16'd3})
  ) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .busy(busy_b), .frame_done(frame_done_b), .cur_layer(cur_layer_b),
    .layer_start(layer_start_b), .layer_done(layer_done_b),
    .xfer_rd_index(rd_b), .xfer_wr_index(wr_b), .xfer_write(xfer_write_b)
`ifdef LAYER_SEQ_PERF_EN
    , .perf_cycles(perf_b)
`endif
  );

  int vectors = 0;
  int misses  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      misses++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Auto-responder for instance A: done rises 5 cycles after layer_start.
  logic auto_en = 1'b0;
  int   dcnt[3] = '{0, 0, 0};
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (auto_en && layer_start_a[k]) begin
        dcnt[k]      = 5;
        auto_done[k] = 1'b0;
      end else if (dcnt[k] > 0) begin
        dcnt[k]      = dcnt[k] - 1;
        auto_done[k] = (dcnt[k] == 0);
      end else begin
        auto_done[k] = 1'b0;
      end
    end
  end

  // Monitor for instance A: per-target write model, gap and lag tracking.
  int          cyc = 0;
  int          wcnt[3] = '{0, 0, 0};
  int          last_cyc[3] = '{0, 0, 0};
  logic [47:0] last_wr[3];
  int          start_cnt[3] = '{0, 0, 0};
  int          fdone_cnt = 0;
  int          seq_err = 0, gap_err = 0, lag_err = 0;
  logic [47:0] prev_rd = '0;
  int          mt, md, mn;
  idx3_t       mexp;

  always @(negedge clk) begin
    cyc++;
    if (layer_start_a[0]) begin
      for (int k = 0; k < 3; k++) wcnt[k] = 0;
    end
    for (int k = 0; k < 3; k++) if (layer_start_a[k]) start_cnt[k]++;
    if (frame_done_a) fdone_cnt++;
    if (xfer_write_a != 3'b000) begin
      if (!$onehot(xfer_write_a) || xfer_write_a[0]) begin
        seq_err++;
      end else begin
        mt = xfer_write_a[1] ? 1 : 2;
        md = (mt == 1) ? 26 : 13;
        mn = wcnt[mt];
        mexp.ch  = 16'(mn / (md * md));
        mexp.row = 16'((mn / md) % md);
        mexp.col = 16'(mn % md);
        if (wr_a !== mexp) seq_err++;
        if (wcnt[mt] > 0 && cyc != last_cyc[mt] + 1) gap_err++;
        if (wr_a !== prev_rd) lag_err++;
        wcnt[mt]++;
        last_cyc[mt] = cyc;
        last_wr[mt]  = wr_a;
      end
    end
    prev_rd = rd_a;
  end

  // Runs one frame on instance A and returns its length in cycles, accept
  // cycle through frame_done inclusive. With poke set, start is pulsed while
  // busy and layer_done[2] is forced during layer 0's WAIT.
  task automatic applyStimulus(input bit poke, output int len);
    int n = 0;
    start_a = 1'b1;
    do begin
      n++;
      @(posedge clk); #1;
      start_a    = poke && ((n + 1 >= 3 && n + 1 <= 5) || (n + 1 >= 1000 && n + 1 <= 1002));
      extra_done = (poke && n + 1 >= 3 && n + 1 <= 5) ? 3'b100 : 3'b000;
    end while (!frame_done_a && n < 30000);
    start_a    = 1'b0;
    extra_done = 3'b000;
    len = n + 1;
    checkOutput("frame_reached_done", frame_done_a, 1'b1);
  endtask

  logic [47:0] exp_b[18] = '{
    {16'd0, 16'd0, 16'd0}, {16'd0, 16'd0, 16'd1}, {16'd0, 16'd0, 16'd2},
    {16'd0, 16'd1, 16'd0}, {16'd0, 16'd1, 16'd1}, {16'd0, 16'd1, 16'd2},
    {16'd0, 16'd2, 16'd0}, {16'd0, 16'd2, 16'd1}, {16'd0, 16'd2, 16'd2},
    {16'd1, 16'd0, 16'd0}, {16'd1, 16'd0, 16'd1}, {16'd1, 16'd0, 16'd2},
    {16'd1, 16'd1, 16'd0}, {16'd1, 16'd1, 16'd1}, {16'd1, 16'd1, 16'd2},
    {16'd1, 16'd2, 16'd0}, {16'd1, 16'd2, 16'd1}, {16'd1, 16'd2, 16'd2}
  };

  int          len, fd0, w, n, bi;
  int          sc0[3];
  logic [47:0] prev_b;

  initial begin
    reset = 1'b0; start_a = 1'b0; abort_a = 1'b0; extra_done = 3'b000;
    start_b = 1'b0; abort_b = 1'b0; layer_done_b = 2'b00;
    repeat (3) @(posedge clk); #1;

    // Reset state
    checkOutput("rst_busy", busy_a, 1'b0);
    checkOutput("rst_frame_done", frame_done_a, 1'b0);
    checkOutput("rst_layer_start", layer_start_a, 3'b000);
    checkOutput("rst_xfer_write", xfer_write_a, 3'b000);
    checkOutput("rst_rd_index", rd_a, 48'd0);
    checkOutput("rst_wr_index", wr_a, 48'd0);
    checkOutput("rst_cur_layer", cur_layer_a, 2'd0);
`ifdef LAYER_SEQ_PERF_EN
    checkOutput("rst_perf", perf_a, 32'd0);
`endif
    reset = 1'b1;
    @(posedge clk); #1;
    auto_en = 1'b1;

    // Test 2: tiny 2-layer build, exact write sequence
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    checkOutput("b_busy", busy_b, 1'b1);
    checkOutput("b_start0", layer_start_b, 2'b01);
    @(posedge clk); #1;
    layer_done_b = 2'b01;
    @(posedge clk); #1;
    layer_done_b = 2'b00;
    prev_b = rd_b;
    bi = 0;
    for (int c = 0; c < 40 && bi < 18; c++) begin
      @(posedge clk); #1;
      if (xfer_write_b != 2'b00) begin
        checkOutput("b_wen", xfer_write_b, 2'b10);
        checkOutput($sformatf("b_wr%0d", bi), wr_b, exp_b[bi]);
        checkOutput($sformatf("b_lag%0d", bi), wr_b, prev_b);
        bi++;
      end
      prev_b = rd_b;
    end
    checkOutput("b_write_count", bi, 18);
    @(posedge clk); #1;
    checkOutput("b_no_extra_write", xfer_write_b, 2'b00);
    checkOutput("b_start1", layer_start_b, 2'b10);
    checkOutput("b_cur_layer", cur_layer_b, 1'b1);
    @(posedge clk); #1;
    layer_done_b = 2'b10;
    @(posedge clk); #1;
    layer_done_b = 2'b00;
    checkOutput("b_frame_done", frame_done_b, 1'b1);
    @(posedge clk); #1;
    checkOutput("b_idle", busy_b, 1'b0);

    // Test 1: default frame
    fd0 = fdone_cnt;
    for (int k = 0; k < 3; k++) sc0[k] = start_cnt[k];
    applyStimulus(1'b0, len);
    checkOutput("t1_len", len, FRAME_LEN);
    checkOutput("t1_busy_in_done", busy_a, 1'b1);
    @(posedge clk); #1;
    checkOutput("t1_busy_after", busy_a, 1'b0);
    checkOutput("t1_fd_after", frame_done_a, 1'b0);
    checkOutput("t1_fd_count", fdone_cnt - fd0, 1);
    checkOutput("t1_l1_writes", wcnt[1], L1_WRITES);
    checkOutput("t1_l2_writes", wcnt[2], L2_WRITES);
    checkOutput("t1_l1_last", last_wr[1], {16'd15, 16'd25, 16'd25});
    checkOutput("t1_l2_last", last_wr[2], {16'd15, 16'd12, 16'd12});
    for (int k = 0; k < 3; k++) checkOutput($sformatf("t1_starts%0d", k), start_cnt[k] - sc0[k], 1);
`ifdef LAYER_SEQ_PERF_EN
    checkOutput("t1_perf", perf_a, len);
`endif

    // Test 3: abort on the cycle presenting write #100
    fd0 = fdone_cnt;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    w = 0; n = 0;
    while (w < 100 && n < 20000) begin
      @(posedge clk); #1;
      n++;
      if (xfer_write_a[1]) w++;
    end
    checkOutput("t3_reach_100", w, 100);
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    checkOutput("t3_busy", busy_a, 1'b0);
    checkOutput("t3_xfer_write", xfer_write_a, 3'b000);
    checkOutput("t3_cur_layer", cur_layer_a, 2'd0);
    checkOutput("t3_writes", wcnt[1], 100);
    checkOutput("t3_last_wr", last_wr[1], {16'd0, 16'd3, 16'd21});
    repeat (20) @(posedge clk);
    #1;
    checkOutput("t3_no_fd", fdone_cnt - fd0, 0);
    checkOutput("t3_still_idle", busy_a, 1'b0);
    applyStimulus(1'b0, len);
    @(posedge clk); #1;
    checkOutput("t3_len", len, FRAME_LEN);
    checkOutput("t3_fd_count", fdone_cnt - fd0, 1);
    checkOutput("t3_l1_writes", wcnt[1], L1_WRITES);
    checkOutput("t3_l2_writes", wcnt[2], L2_WRITES);
`ifdef LAYER_SEQ_PERF_EN
    checkOutput("t3_perf", perf_a, FRAME_LEN);
`endif

    // Test 4: start while busy and stray done for layer 2
    fd0 = fdone_cnt;
    for (int k = 0; k < 3; k++) sc0[k] = start_cnt[k];
    applyStimulus(1'b1, len);
    @(posedge clk); #1;
    checkOutput("t4_len", len, FRAME_LEN);
    checkOutput("t4_fd_count", fdone_cnt - fd0, 1);
    for (int k = 0; k < 3; k++) checkOutput($sformatf("t4_starts%0d", k), start_cnt[k] - sc0[k], 1);
    checkOutput("t4_l2_writes", wcnt[2], L2_WRITES);

    checkOutput("seq_errors", seq_err, 0);
    checkOutput("gap_errors", gap_err, 0);
    checkOutput("lag_errors", lag_err, 0);

    // Test 5: async reset during layer 1's DRAIN
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    w = 0; n = 0;
    while (w < L2_WRITES && n < 20000) begin
      @(posedge clk); #1;
      n++;
      if (xfer_write_a[2]) w++;
    end
    checkOutput("t5_reach_drain", w, L2_WRITES);
    checkOutput("t5_pre_cur_layer", cur_layer_a, 2'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t5_busy", busy_a, 1'b0);
    checkOutput("t5_xfer_write", xfer_write_a, 3'b000);
    checkOutput("t5_cur_layer", cur_layer_a, 2'd0);
    checkOutput("t5_wr_index", wr_a, 48'd0);
    checkOutput("t5_rd_index", rd_a, 48'd0);
    checkOutput("t5_frame_done", frame_done_a, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t5_idle_after", busy_a, 1'b0);
    checkOutput("t5_no_start", layer_start_a, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
